pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, PC/operand width.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_sel  in  2  {b_jal,jalr} redirect select from branch judge
- ex_valid  in  1  pc_sel/ex_pc/imme/rs1 valid this cycle
- ex_pc  in  DATA_WIDTH  PC of the resolving instruction
- imme  in  DATA_WIDTH  sign-extended immediate
- rs1  in  DATA_WIDTH  rs1 operand for jalr
- if_req  out  1  imem request valid
- if_addr  out  DATA_WIDTH  imem request address
- if_gnt  in  1  imem accepts request
- if_rvalid  in  1  imem response valid
- if_rdata  in  32  imem response instruction
- inst_valid  out  1  instruction offered to decode
- inst  out  32  instruction
- inst_pc  out  DATA_WIDTH  instruction PC
- id_ready  in  1  decode accepts instruction
- flush  out  1  one-cycle pulse: kill younger instructions

Function
REQ-004 SHALL treat redirect as ex_valid & |pc_sel; pc_sel 2'b01 or 2'b11: target = (rs1+imme) & ~1 (jalr wins); 2'b10: target = ex_pc+imme.
REQ-005 SHALL wrap all address arithmetic modulo 2^DATA_WIDTH; sequential next PC = pc+4.
REQ-006 SHALL use FSM states REQ, WAIT, HOLD; at most one outstanding imem request.
REQ-007 REQ: if_req=1, if_addr=pc; if_gnt -> WAIT.
REQ-008 WAIT: if_req=0; if_rvalid -> capture if_rdata/pc into buffer, pc<=pc+4, -> HOLD.
REQ-009 HOLD: inst_valid=1; inst_valid&id_ready -> REQ; inst/inst_pc stable while held.
REQ-010 Redirect in any state SHALL: pulse flush for exactly that cycle, pc<=target next cycle, clear inst_valid next cycle.
REQ-011 Redirect in REQ: go to REQ with target address; an if_gnt in the same cycle SHALL mark the response wrong-path.
REQ-012 Redirect in WAIT (or gnt coinciding): set drop flag; stay in WAIT; matching if_rvalid discarded (inst_valid stays 0), then -> REQ at target.
REQ-013 Redirect coinciding with if_rvalid in WAIT: response discarded, -> REQ at target.
REQ-014 Redirect in HOLD: buffered instruction discarded, -> REQ at target; id_ready ignored that cycle.
REQ-015 if_req SHALL NOT drop or if_addr change while in REQ without if_gnt, except on redirect.
REQ-016 Latency: reset release to first if_req = 1 cycle; redirect cycle to if_req at target = 1 cycle (no outstanding), or 1 cycle after the discarded response.

Reset
REQ-017 On rst: state=REQ, pc=RESET_PC, drop=0, if_req=0, inst_valid=0, inst=0, inst_pc=0, flush=0; if_req first asserts the cycle after rst deasserts.
REQ-018 rst mid-transaction SHALL abandon any outstanding request; responses arriving in the first cycle after reset are ignored.

Configuration
REQ-019 Macro PC_MISALIGN_EXC_EN defined: extra output misalign_exc (1 bit, reset 0) pulses with flush when target[1:0]!=0; pc is NOT updated, FSM halts in REQ with if_req=0 until rst.
REQ-020 Macro undefined: no misalign_exc port; target bit 1 forced to 0 (word-aligned fetch).

Structure
REQ-021 Shared package rv64_pkg SHALL hold pc_sel encodings, FSM state enum, default RESET_PC, instruction width constant.
REQ-022 Sub-module branch_target SHALL compute the redirect target (combinational, both adders plus select).

Verification
REQ-023 Reset release, if_gnt/if_rvalid 1-cycle each, id_ready=1 -> if_addr sequence 0x0, 0x4, 0x8; inst_pc matches.
REQ-024 In HOLD, ex_valid=1, pc_sel=2'b10, ex_pc=0x100, imme=0x20 -> flush 1 cycle, next if_addr=0x120, held instruction never accepted.
REQ-025 In WAIT, ex_valid=1, pc_sel=2'b01, rs1=0x2001, imme=0x10 -> drop; following rvalid not presented; next if_addr=0x2010.
REQ-026 id_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new if_req.
REQ-027 pc=0xFFFF_FFFF_FFFF_FFFC sequential -> next if_addr=0x0.
REQ-028 With PC_MISALIGN_EXC_EN, pc_sel=2'b10, ex_pc=0x100, imme=0x2 -> misalign_exc=1 with flush, no further if_req.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64 fetch front end.
//   - pc_sel redirect encodings coming from the branch judge
//   - fetch FSM state enum
//   - default reset PC and instruction width
package rv64_pkg;

  localparam int unsigned InstWidth      = 32;
  localparam logic [63:0] DefaultResetPc = 64'h0;

  // pc_sel = {b_jal, jalr}; jalr has priority when both are set.
  localparam logic [1:0] PcSelSeq     = 2'b00;
  localparam logic [1:0] PcSelJalr    = 2'b01;
  localparam logic [1:0] PcSelBranch  = 2'b10;
  localparam logic [1:0] PcSelJalrAlt = 2'b11;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

  function automatic logic is_jalr(input logic [1:0] sel);
    return (sel == PcSelJalr) || (sel == PcSelJalrAlt);
  endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational redirect target computation.
// Ports:
//   pc_sel  - {b_jal, jalr} redirect select
//   ex_pc   - PC of the resolving instruction
//   imme    - sign-extended immediate
//   rs1     - rs1 operand (jalr base)
//   target  - jalr: (rs1 + imme) & ~1, branch/jal: ex_pc + imme (modulo 2^DATA_WIDTH)
module branch_target
  import rv64_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [1:0]            pc_sel,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] imme,
  input  logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] target
);

  logic [DATA_WIDTH-1:0] br_sum;
  logic [DATA_WIDTH-1:0] jalr_sum;

  assign br_sum   = ex_pc + imme;
  assign jalr_sum = rs1 + imme;

  always_comb begin
    target = br_sum;
    case (pc_sel)
      PcSelJalr, PcSelJalrAlt: target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
      PcSelBranch:             target = br_sum;
      default:                 target = br_sum;  // no redirect, value unused
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one imem request at a time,
// buffers the returned instruction for decode and handles redirects.
// Optional feature macro: PC_MISALIGN_EXC_EN
//   defined   - misaligned redirect targets raise misalign_exc and halt fetch
//   undefined - target bit 1 is forced to 0 (word-aligned fetch)
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   pc_sel, ex_valid, ex_pc, - redirect request from execute
//   imme, rs1
//   if_req, if_addr, if_gnt  - imem request handshake
//   if_rvalid, if_rdata      - imem response
//   inst_valid, inst,        - instruction offered to decode
//   inst_pc, id_ready
//   misalign_exc             - (macro only) misaligned redirect target
//   flush                    - one-cycle pulse on redirect
module pc_fetch_unit
  import rv64_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DefaultResetPc)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            pc_sel,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] imme,
  input  logic [DATA_WIDTH-1:0] rs1,
  output logic                  if_req,
  output logic [DATA_WIDTH-1:0] if_addr,
  input  logic                  if_gnt,
  input  logic                  if_rvalid,
  input  logic [InstWidth-1:0]  if_rdata,
  output logic                  inst_valid,
  output logic [InstWidth-1:0]  inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  id_ready,
`ifdef PC_MISALIGN_EXC_EN
  output logic                  misalign_exc,
`endif
  output logic                  flush
);

  localparam logic [DATA_WIDTH-1:0] PcStep = DATA_WIDTH'(4);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [InstWidth-1:0]  inst_q, inst_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  // Delayed reset: keeps if_req low for the first cycle after reset so a
  // stale response from an abandoned request can't be mistaken for ours.
  logic                  in_reset_q;

  logic                  redirect;
  logic [DATA_WIDTH-1:0] raw_target;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  fetch_halted;

  assign redirect = ex_valid & (pc_sel != PcSelSeq);

  branch_target #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_branch_target (
    .pc_sel(pc_sel),
    .ex_pc (ex_pc),
    .imme  (imme),
    .rs1   (rs1),
    .target(raw_target)
  );

`ifdef PC_MISALIGN_EXC_EN
  logic misaligned;
  logic halt_q;

  assign misaligned   = redirect & (raw_target[1:0] != 2'b00);
  // A faulting redirect leaves the PC untouched.
  assign redirect_pc  = misaligned ? pc_q : raw_target;
  assign fetch_halted = halt_q;
  assign misalign_exc = misaligned & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (misaligned) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign redirect_pc  = {raw_target[DATA_WIDTH-1:2], 1'b0, raw_target[0]};
  assign fetch_halted = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      StReq: begin
        // A grant in the redirect cycle was for the old address: wrong path.
        if (if_req && if_gnt) begin
          state_d = StWait;
          drop_d  = redirect;
        end
        if (redirect) begin
          pc_d = redirect_pc;
        end
      end
      StWait: begin
        if (if_rvalid) begin
          if (redirect || drop_q) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            inst_d    = if_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PcStep;
            state_d   = StHold;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
        if (redirect) begin
          pc_d = redirect_pc;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StReq;
          pc_d    = redirect_pc;
        end else if (id_ready) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    in_reset_q <= rst;
  end

  assign if_req     = (state_q == StReq) & ~rst & ~in_reset_q & ~fetch_halted;
  assign if_addr    = pc_q;
  // Masked during a redirect so a held instruction is never accepted.
  assign inst_valid = (state_q == StHold) & ~rst & ~redirect;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign flush      = redirect & ~rst;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] imme;
  logic [63:0] rs1;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;
  logic        flush;
`ifdef PC_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  int total;
  int bad;

  pc_fetch_unit #(
    .DATA_WIDTH(64),
    .RESET_PC  (64'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .imme        (imme),
    .rs1         (rs1),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .id_ready    (id_ready),
`ifdef PC_MISALIGN_EXC_EN
    .misalign_exc(misalign_exc),
`endif
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks run #1 later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h100; imme = 64'h20;
    #1;
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL rst_if_req got=%0h want=0", if_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%0h want=0", inst_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h want=0", flush); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%0h want=0", inst); end
    total++; if (inst_pc !== 64'h0) begin bad++; $display("FAIL rst_inst_pc got=%0h want=0", inst_pc); end
    ex_valid = 1'b0; pc_sel = 2'b00;
    rst = 1'b0;
    #1;
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL rel_c0_if_req got=%0h want=0", if_req); end
    tick(); #1;
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL rel_c1_if_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h0) begin bad++; $display("FAIL rel_c1_if_addr got=%0h want=0", if_addr); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_addr;
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 64'(4 * i);
      word     = 32'h1000_0000 | 32'(i);
      if_gnt = 1'b1; #1;
      total++; if (if_req !== 1'b1) begin bad++; $display("FAIL seq_req got=%0h want=1", if_req); end
      total++; if (if_addr !== exp_addr) begin bad++; $display("FAIL seq_addr got=%0h want=%0h", if_addr, exp_addr); end
      tick();
      if_gnt = 1'b0; if_rvalid = 1'b1; if_rdata = word; #1;
      total++; if (if_req !== 1'b0) begin bad++; $display("FAIL seq_wait_req got=%0h want=0", if_req); end
      tick();
      if_rvalid = 1'b0; if_rdata = 32'h0; id_ready = 1'b1; #1;
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%0h want=1", inst_valid); end
      total++; if (inst !== word) begin bad++; $display("FAIL seq_inst got=%0h want=%0h", inst, word); end
      total++; if (inst_pc !== exp_addr) begin bad++; $display("FAIL seq_inst_pc got=%0h want=%0h", inst_pc, exp_addr); end
      tick();
      id_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    // pc is 0xC on entry
    if_gnt = 1'b1; #1;
    tick();
    if_gnt = 1'b0; if_rvalid = 1'b1; if_rdata = 32'hCAFE_0003;
    tick();
    if_rvalid = 1'b0; if_rdata = 32'h0; id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h want=1", inst_valid); end
      total++; if (inst !== 32'hCAFE_0003) begin bad++; $display("FAIL stall_inst got=%0h want=cafe0003", inst); end
      total++; if (inst_pc !== 64'hC) begin bad++; $display("FAIL stall_inst_pc got=%0h want=c", inst_pc); end
      total++; if (if_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0h want=0", if_req); end
      tick();
    end
  endtask

  task automatic test_redirect_hold();
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h100; imme = 64'h20; id_ready = 1'b1; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL hold_flush got=%0h want=1", flush); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL hold_accept got=%0h want=0", inst_valid); end
    tick();
    ex_valid = 1'b0; pc_sel = 2'b00; id_ready = 1'b0; #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL hold_flush_end got=%0h want=0", flush); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_after got=%0h want=0", inst_valid); end
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL hold_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h120) begin bad++; $display("FAIL hold_addr got=%0h want=120", if_addr); end
  endtask

  task automatic test_redirect_wait();
    if_gnt = 1'b1; #1;
    tick();
    if_gnt = 1'b0;
    ex_valid = 1'b1; pc_sel = 2'b01; rs1 = 64'h2001; imme = 64'h10; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL wait_flush got=%0h want=1", flush); end
    tick();
    ex_valid = 1'b0; pc_sel = 2'b00;
    if_rvalid = 1'b1; if_rdata = 32'hDEAD_BEEF; #1;
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL wait_still_req got=%0h want=0", if_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL wait_drop_valid got=%0h want=0", inst_valid); end
    tick();
    if_rvalid = 1'b0; #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL wait_after_valid got=%0h want=0", inst_valid); end
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL wait_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h2010) begin bad++; $display("FAIL wait_addr got=%0h want=2010", if_addr); end
  endtask

  task automatic test_redirect_req_gnt();
    if_gnt = 1'b1; ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h300; imme = 64'h0; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL reqgnt_flush got=%0h want=1", flush); end
    tick();
    if_gnt = 1'b0; ex_valid = 1'b0; pc_sel = 2'b00;
    if_rvalid = 1'b1; if_rdata = 32'h0BAD_0BAD; #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reqgnt_valid got=%0h want=0", inst_valid); end
    tick();
    if_rvalid = 1'b0; #1;
    total++; if (if_addr !== 64'h300) begin bad++; $display("FAIL reqgnt_addr got=%0h want=300", if_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reqgnt_valid2 got=%0h want=0", inst_valid); end
  endtask

  task automatic test_redirect_rvalid();
    if_gnt = 1'b1; #1;
    tick();
    if_gnt = 1'b0; if_rvalid = 1'b1; if_rdata = 32'h1234_5678;
    ex_valid = 1'b1; pc_sel = 2'b11; rs1 = 64'h400; imme = 64'h4; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL rv_flush got=%0h want=1", flush); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rv_valid got=%0h want=0", inst_valid); end
    tick();
    if_rvalid = 1'b0; ex_valid = 1'b0; pc_sel = 2'b00; #1;
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL rv_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h404) begin bad++; $display("FAIL rv_addr got=%0h want=404", if_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rv_valid2 got=%0h want=0", inst_valid); end
  endtask

  task automatic test_wrap();
    ex_valid = 1'b1; pc_sel = 2'b01; rs1 = 64'hFFFF_FFFF_FFFF_FFF0; imme = 64'hC; #1;
    tick();
    ex_valid = 1'b0; pc_sel = 2'b00; #1;
    total++; if (if_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%0h want=fffffffffffffffc", if_addr); end
    if_gnt = 1'b1;
    tick();
    if_gnt = 1'b0; if_rvalid = 1'b1; if_rdata = 32'h0000_0013;
    tick();
    if_rvalid = 1'b0; id_ready = 1'b1; #1;
    total++; if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_inst_pc got=%0h want=fffffffffffffffc", inst_pc); end
    tick();
    id_ready = 1'b0; #1;
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr got=%0h want=0", if_addr); end
  endtask

  task automatic test_reset_mid();
    if_gnt = 1'b1; #1;
    tick();
    if_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; if_rvalid = 1'b1; if_rdata = 32'h5555_AAAA; #1;
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL mid_c0_req got=%0h want=0", if_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mid_c0_valid got=%0h want=0", inst_valid); end
    tick();
    if_rvalid = 1'b0; #1;
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h0) begin bad++; $display("FAIL mid_addr got=%0h want=0", if_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0h want=0", inst_valid); end
  endtask

`ifdef PC_MISALIGN_EXC_EN
  task automatic test_misalign();
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h100; imme = 64'h2; #1;
    total++; if (misalign_exc !== 1'b1) begin bad++; $display("FAIL mis_exc got=%0h want=1", misalign_exc); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL mis_flush got=%0h want=1", flush); end
    tick();
    ex_valid = 1'b0; pc_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL mis_exc_end got=%0h want=0", misalign_exc); end
      total++; if (if_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h want=0", if_req); end
      total++; if (if_addr !== 64'h0) begin bad++; $display("FAIL mis_addr got=%0h want=0", if_addr); end
      tick();
    end
  endtask
`else
  task automatic test_align();
    // 0x100 + 0x2 = 0x102; bit 1 is cleared to keep fetch word aligned
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h100; imme = 64'h2; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL align_flush got=%0h want=1", flush); end
    tick();
    ex_valid = 1'b0; pc_sel = 2'b00; #1;
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL align_req got=%0h want=1", if_req); end
    total++; if (if_addr !== 64'h100) begin bad++; $display("FAIL align_addr got=%0h want=100", if_addr); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    pc_sel = 2'b00; ex_valid = 1'b0; ex_pc = '0; imme = '0; rs1 = '0;
    if_gnt = 1'b0; if_rvalid = 1'b0; if_rdata = '0; id_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_redirect_req_gnt();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
`ifdef PC_MISALIGN_EXC_EN
    test_misalign();
`else
    test_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
